// File: rtl/matmul_stream_ctrl_pkg.sv
// Shared definitions for the 2x2 matrix multiplier stream controller.
// Package name: matmul_pkg.
package matmul_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_RES_W  = 2 * DEF_DATA_W;

   localparam int N_IN  = 8;
   localparam int N_OUT = 4;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/matmul_stream_ctrl_if.sv
// Element-in / result-out valid-ready stream pair for matmul_stream_ctrl.
// master: host/fabric side, slave: controller side.
interface matmul_stream_ctrl_if
   import matmul_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int RES_W  = DEF_RES_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [RES_W-1:0]  out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/matmul_stream_ctrl.sv
// Stream-side initiator for the 2x2 matrix multiplier: collects A0..A3,B0..B3,
// pulses mm_start, captures C0..C3 and returns them as a word stream.
// Optional feature: MATMUL_CTRL_OPCNT_EN adds the op_count output.
//
//   state | meaning
//   LOAD  | accept elements into operand regs, idx 0..7
//   START | one-cycle mm_start pulse
//   WAIT  | hold until mm_done, then capture results
//   DRAIN | present result[oidx] until four words have been taken
module matmul_stream_ctrl
   import matmul_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int RES_W  = 2 * DATA_W
)
(
   input  logic              clk,
   input  logic              rst_n,
`ifdef MATMUL_CTRL_OPCNT_EN
   output logic [15:0]       op_count,
`endif
   matmul_stream_ctrl_if.slave bus,
   output logic              busy,
   output logic              mm_start,
   output logic [DATA_W-1:0] mm_A0,
   output logic [DATA_W-1:0] mm_A1,
   output logic [DATA_W-1:0] mm_A2,
   output logic [DATA_W-1:0] mm_A3,
   output logic [DATA_W-1:0] mm_B0,
   output logic [DATA_W-1:0] mm_B1,
   output logic [DATA_W-1:0] mm_B2,
   output logic [DATA_W-1:0] mm_B3,
   input  logic              mm_done,
   input  logic [RES_W-1:0]  mm_C0,
   input  logic [RES_W-1:0]  mm_C1,
   input  logic [RES_W-1:0]  mm_C2,
   input  logic [RES_W-1:0]  mm_C3
);

   localparam logic [2:0] LAST_IN  = 3'(N_IN - 1);
   localparam logic [1:0] LAST_OUT = 2'(N_OUT - 1);

   state_e            state_q, state_d;
   logic [2:0]        idx;
   logic [1:0]        oidx;
   logic [DATA_W-1:0] opnd [N_IN];
   logic [RES_W-1:0]  res  [N_OUT];
   logic              in_fire, out_fire;

   // Handshake outputs decode straight from state; out_data is zero outside DRAIN.
   assign bus.in_ready  = (state_q == LOAD);
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.out_data  = (state_q == DRAIN) ? res[oidx] : '0;
   assign busy          = (state_q != LOAD);
   assign mm_start      = (state_q == START);

   assign in_fire  = bus.in_valid  & bus.in_ready;
   assign out_fire = bus.out_valid & bus.out_ready;

   assign mm_A0 = opnd[0];
   assign mm_A1 = opnd[1];
   assign mm_A2 = opnd[2];
   assign mm_A3 = opnd[3];
   assign mm_B0 = opnd[4];
   assign mm_B1 = opnd[5];
   assign mm_B2 = opnd[6];
   assign mm_B3 = opnd[7];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= LOAD;
      else        state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (in_fire && idx == LAST_IN)    state_d = START;
         START:                                     state_d = WAIT;
         WAIT:    if (mm_done)                      state_d = DRAIN;
         DRAIN:   if (out_fire && oidx == LAST_OUT) state_d = LOAD;
         default:                                   state_d = LOAD;
      endcase
   end

   // Operand load: the only writer of mm_A*/mm_B*, so they stay put past LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         for (int i = 0; i < N_IN; i++) opnd[i] <= '0;
      end else if (in_fire) begin
         opnd[idx] <= bus.in_data;
         idx       <= (idx == LAST_IN) ? 3'd0 : idx + 3'd1;
      end
   end

   // Result capture in WAIT; WAIT is only reached after the start edge, so a
   // sticky done from the previous operation already comes with fresh results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_OUT; i++) res[i] <= '0;
      end else if (state_q == WAIT && mm_done) begin
         res[0] <= mm_C0;
         res[1] <= mm_C1;
         res[2] <= mm_C2;
         res[3] <= mm_C3;
      end
   end

   // Output word index; holds under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        oidx <= '0;
      else if (out_fire) oidx <= (oidx == LAST_OUT) ? 2'd0 : oidx + 2'd1;
   end

`ifdef MATMUL_CTRL_OPCNT_EN
   // Completed-operation counter, wraps at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            op_count <= '0;
      else if (out_fire && oidx == LAST_OUT) op_count <= op_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed bench for matmul_stream_ctrl with a behavioural 2x2 multiplier and
// a result scoreboard fed from the stimulus bytes.
module tb_matmul_stream_ctrl;
   import matmul_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy, mm_start, mm_done;
   logic [7:0]  mm_A0, mm_A1, mm_A2, mm_A3, mm_B0, mm_B1, mm_B2, mm_B3;
   logic [15:0] mm_C0, mm_C1, mm_C2, mm_C3;
`ifdef MATMUL_CTRL_OPCNT_EN
   logic [15:0] op_count;
`endif

   int          vectors = 0;
   int          miscompares = 0;
   int          start_cnt = 0;
   int          mm_lat = 0;
   int          lat_cnt;
   int          wcnt = 0;
   bit          rdy_chk = 0;
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   matmul_stream_ctrl_if #(.DATA_W(8), .RES_W(16)) bus ();

   matmul_stream_ctrl #(.DATA_W(8), .RES_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef MATMUL_CTRL_OPCNT_EN
      .op_count (op_count),
`endif
      .bus      (bus),
      .busy     (busy),
      .mm_start (mm_start),
      .mm_A0    (mm_A0), .mm_A1(mm_A1), .mm_A2(mm_A2), .mm_A3(mm_A3),
      .mm_B0    (mm_B0), .mm_B1(mm_B1), .mm_B2(mm_B2), .mm_B3(mm_B3),
      .mm_done  (mm_done),
      .mm_C0    (mm_C0), .mm_C1(mm_C1), .mm_C2(mm_C2), .mm_C3(mm_C3)
   );

   // Reference 2x2 product with 16-bit wrap; C0 in [15:0] .. C3 in [63:48].
   function automatic logic [63:0] mm_ref(input logic [7:0] a0, a1, a2, a3,
                                          input logic [7:0] b0, b1, b2, b3);
      logic [15:0] x0, x1, x2, x3, y0, y1, y2, y3, c0, c1, c2, c3;
      x0 = {8'd0, a0}; x1 = {8'd0, a1}; x2 = {8'd0, a2}; x3 = {8'd0, a3};
      y0 = {8'd0, b0}; y1 = {8'd0, b1}; y2 = {8'd0, b2}; y3 = {8'd0, b3};
      c0 = x0 * y0 + x1 * y2;
      c1 = x0 * y1 + x1 * y3;
      c2 = x2 * y0 + x3 * y2;
      c3 = x2 * y1 + x3 * y3;
      return {c3, c2, c1, c0};
   endfunction

   // Multiplier stand-in: results update on the start edge, done is sticky
   // and rises mm_lat cycles later (immediately when mm_lat is 0).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mm_done <= 1'b0;
         lat_cnt <= 0;
         {mm_C3, mm_C2, mm_C1, mm_C0} <= '0;
      end else if (mm_start) begin
         {mm_C3, mm_C2, mm_C1, mm_C0} <= mm_ref(mm_A0, mm_A1, mm_A2, mm_A3,
                                                mm_B0, mm_B1, mm_B2, mm_B3);
         if (mm_lat == 0) mm_done <= 1'b1;
         else             lat_cnt <= mm_lat;
      end else if (lat_cnt != 0) begin
         lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) mm_done <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every word transfer and checks
   // that the controller is back in LOAD the cycle after each fourth word.
   always @(negedge clk) begin
      if (mm_start) start_cnt++;
      if (!rst_n) begin
         wcnt    = 0;
         rdy_chk = 0;
      end else begin
         if (rdy_chk) begin
            chk("in_ready_after_final", {31'd0, bus.in_ready}, 32'd1);
            chk("busy_after_final", {31'd0, busy}, 32'd0);
            rdy_chk = 0;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $error("FAIL unexpected_word observed=%h expected=none", bus.out_data);
            end else begin
               chk("out_data", {16'd0, bus.out_data}, {16'd0, exp_q.pop_front()});
            end
            if (wcnt == 3) begin
               wcnt    = 0;
               rdy_chk = 1;
            end else begin
               wcnt++;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_elem(input logic [7:0] d);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_op(input logic [7:0] e [8], input bit push);
      logic [63:0] r;
      if (push) begin
         r = mm_ref(e[0], e[1], e[2], e[3], e[4], e[5], e[6], e[7]);
         exp_q.push_back(r[15:0]);
         exp_q.push_back(r[31:16]);
         exp_q.push_back(r[47:32]);
         exp_q.push_back(r[63:48]);
      end
      for (int i = 0; i < 8; i++) send_elem(e[i]);
   endtask

   task automatic wait_drained(input string tag);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (exp_q.size() != 0 && n < 300);
      chk(tag, exp_q.size(), 32'd0);
   endtask

   task automatic wait_out_valid(input string tag);
      int n = 0;
      while (!bus.out_valid && n < 100) begin
         cyc(1);
         n++;
      end
      chk(tag, {31'd0, bus.out_valid}, 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
      chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, "_busy"},      {31'd0, busy},          32'd0);
      chk({tag, "_mm_start"},  {31'd0, mm_start},      32'd0);
      chk({tag, "_out_data"},  {16'd0, bus.out_data},  32'd0);
      chk({tag, "_operands"},  {mm_A0, mm_A3, mm_B0, mm_B3}, 32'd0);
`ifdef MATMUL_CTRL_OPCNT_EN
      chk({tag, "_op_count"},  {16'd0, op_count},      32'd0);
`endif
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      exp_q.delete();
      cyc(2);
      check_reset_vals(tag);
      start_cnt = 0;
      rst_n = 1'b1;
      cyc(1);
   endtask

   initial begin
      logic [7:0] e_basic [8];
      logic [7:0] e_ff    [8];
      logic [7:0] e_two   [8];
      e_basic = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      e_ff    = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      e_two   = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      cyc(1);
      do_reset("reset");

      // Basic operation with latency checks from the last acceptance (edge N).
      bus.out_ready = 1'b1;
      send_op(e_basic, 1'b1);
      chk("lat_start_n1", {31'd0, mm_start}, 32'd1);
      chk("lat_ovalid_n1", {31'd0, bus.out_valid}, 32'd0);
      cyc(1);
      chk("lat_start_n2", {31'd0, mm_start}, 32'd0);
      chk("lat_ovalid_n2", {31'd0, bus.out_valid}, 32'd0);
      chk("lat_busy_n2", {31'd0, busy}, 32'd1);
      cyc(1);
      chk("lat_ovalid_n3", {31'd0, bus.out_valid}, 32'd1);
      wait_drained("basic_drain");
      chk("basic_start_pulses", start_cnt, 32'd1);
      chk("basic_busy_end", {31'd0, busy}, 32'd0);

      // All-0xFF operands: results wrap to 0xFC02.
      send_op(e_ff, 1'b1);
      wait_drained("ovf_drain");

      // Backpressure while C1 is presented.
      bus.out_ready = 1'b0;
      send_op(e_basic, 1'b1);
      wait_out_valid("bp_valid");
      chk("bp_c0", {16'd0, bus.out_data}, 32'd19);
      bus.out_ready = 1'b1;
      cyc(1);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("bp_hold", {16'd0, bus.out_data}, 32'd22);
      end
      bus.out_ready = 1'b1;
      wait_drained("bp_drain");

      // Input gating during DRAIN.
      bus.out_ready = 1'b0;
      send_op(e_basic, 1'b1);
      wait_out_valid("gate_valid");
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("gate_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("gate_operands", {mm_A0, mm_A3, mm_B0, mm_B3}, {8'd1, 8'd4, 8'd5, 8'd8});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_drained("gate_drain");
      send_op(e_two, 1'b1);
      wait_drained("gate_next_drain");

      // Reset after five elements.
      for (int i = 0; i < 5; i++) send_elem(8'd9);
      do_reset("rst_load");

      // Reset in WAIT (slow done).
      mm_lat = 20;
      send_op(e_basic, 1'b0);
      cyc(3);
      chk("wait_state_busy", {30'd0, busy, bus.out_valid}, 32'd2);
      do_reset("rst_wait");
      cyc(4);
      chk("rst_wait_no_start", start_cnt, 32'd0);
      mm_lat = 0;

      // Reset in DRAIN.
      send_op(e_ff, 1'b0);
      wait_out_valid("drain_valid");
      do_reset("rst_drain");

      // Fresh load after reset.
      bus.out_ready = 1'b1;
      send_op(e_basic, 1'b1);
      wait_drained("fresh_drain");
      chk("fresh_start_pulses", start_cnt, 32'd1);

      // Back-to-back operations from a clean counter.
      do_reset("rst_b2b");
      bus.out_ready = 1'b1;
      send_op(e_basic, 1'b1);
      send_op(e_two, 1'b1);
      wait_drained("b2b_drain");
      chk("b2b_start_pulses", start_cnt, 32'd2);
`ifdef MATMUL_CTRL_OPCNT_EN
      chk("b2b_op_count", {16'd0, op_count}, 32'd2);
`endif
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/matmul_stream_ctrl.md
# matmul_stream_ctrl

Stream-side initiator for the 2x2 matrix multiplier. It collects eight 8-bit elements from a byte stream (A0..A3, then B0..B3), presents them to the multiplier and pulses its start. It captures the four 16-bit results and returns them as a word stream, with valid/ready handshakes on both sides. It sits between the host/stream fabric and the multiplier instance, which lives in the parent.

## Interface
Parameters:
- DATA_W, 8, element width; must match the multiplier operand width.
- RES_W, 2*DATA_W, result width; must match the multiplier result width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts an element; transfer = in_valid & in_ready.
- in_data  in  DATA_W  element; order A0,A1,A2,A3,B0,B1,B2,B3.
- out_valid  out  1  result word valid.
- out_ready  in  1  sink accepts a word; transfer = out_valid & out_ready.
- out_data  out  RES_W  result; order C0,C1,C2,C3.
- busy  out  1  high in every state except LOAD.
- mm_start  out  1  one-cycle start pulse to the multiplier.
- mm_A0..mm_A3, mm_B0..mm_B3  out  DATA_W each  operand registers to the multiplier.
- mm_done  in  1  multiplier done (level; sticky once set).
- mm_C0..mm_C3  in  RES_W each  multiplier results.
- op_count  out  16  only with MATMUL_CTRL_OPCNT_EN; see Configuration.

## Operation
- States: LOAD, START, WAIT, DRAIN.
- LOAD:
  - in_ready=1.
  - Each accepted element is written to operand register idx, where idx is a 3-bit counter 0..7; 0..3 go to A, 4..7 go to B.
  - Acceptance at idx=7 moves to START and clears idx.
- START: mm_start=1 for exactly this cycle; go to WAIT unconditionally.
- WAIT:
  - If mm_done=1, capture mm_C0..mm_C3 into result registers and go to DRAIN.
  - Otherwise stay in WAIT.
  - Because WAIT is entered only after the start edge, a done still high from a previous operation already accompanies updated results.
- DRAIN:
  - out_valid=1 and out_data=result[oidx], where oidx is a 2-bit counter.
  - A transfer advances oidx.
  - A transfer at oidx=3 returns to LOAD and clears oidx.
- mm_A*/mm_B* change only on LOAD acceptances, so they are stable throughout START/WAIT/DRAIN.
- Arithmetic is done entirely in the multiplier. Results are passed through unmodified; a 16-bit wrap of the sum is upstream behaviour, not an error here.
- in_valid outside LOAD is ignored (in_ready=0). No element is lost or duplicated.

## Timing
- Reset (async assert, sync release):
  - state=LOAD, idx=0, oidx=0.
  - in_ready=1, out_valid=0, busy=0, mm_start=0, out_data=0.
  - All operand and result registers 0; op_count=0.
- Latency:
  - Last element accepted at edge N.
  - mm_start high in cycle N+1 and WAIT in cycle N+2, with capture at the end of N+2 when mm_done=1.
  - out_valid high from cycle N+3.
- Backpressure: while out_valid=1 and out_ready=0, out_data and oidx hold.
- Final word accepted at edge M: in_ready=1 in cycle M+1, so back-to-back operations are possible.
- Reset asserted in any state aborts immediately. Partial loads and undrained results are discarded, and no mm_start is issued after reset.

## Configuration
- MATMUL_CTRL_OPCNT_EN defined:
  - Adds the op_count output.
  - op_count increments on each final-word transfer (oidx=3) and wraps from 0xFFFF to 0.
- MATMUL_CTRL_OPCNT_EN not defined: no port and no counter logic; all other behaviour is identical.

## Structure
- Shared package matmul_pkg holds:
  - DATA_W and RES_W defaults.
  - Element counts (N_IN=8, N_OUT=4).
  - The state enum (LOAD, START, WAIT, DRAIN).
- No sub-module: the controller is one module, and the multiplier is instantiated alongside it by the parent.

## Test plan
- Basic: stream 1,2,3,4,5,6,7,8 with out_ready=1 -> exactly one mm_start pulse; outputs 19, 22, 43, 50; busy falls after the fourth word.
- Overflow passthrough: all eight elements 0xFF -> four words of 0xFC02.
- Backpressure: drop out_ready for 3 cycles while C1 is presented -> out_data holds 22, no skip; then 43, 50 follow.
- Input gating: hold in_valid=1 with data 0xAA throughout DRAIN -> in_ready=0, no operand change; the next operation loads only the elements sent after return to LOAD.
- Reset mid-operation: assert rst_n=0 after 5 elements, then in WAIT, then in DRAIN -> all outputs at reset values; a fresh 8-element load then gives correct results.
- Back-to-back: two operations with no idle cycles (second set 2,0,0,2,3,4,5,6 -> 6, 8, 10, 12) -> in_ready=1 in the cycle after the final word; with MATMUL_CTRL_OPCNT_EN, op_count=2.
